// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
//
// ID/EX pipeline register for the 5-stage MIPS32 pipe, with built-in load-use
// hazard detection.
//
// Every decoded field coming out of ID is captured on the rising clock edge and
// presented to EX as ID_EX_<field>. A bubble (all fields zero, Valid = 0) is
// inserted when a branch/jump flushes the pipe or when the instruction in ID
// needs the result of a load that is currently in EX. An external Hold freezes
// the whole register, including the stall counter.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   Hold                       freeze everything (highest priority)
//   Flush                      insert a bubble on the next edge
//   IF_ID_Rs / IF_ID_Rt        source register indices of the instruction in ID
//   IF_ID_UsesRt               ID instruction actually reads rt
//   ID_WriteReg                destination register chosen in ID
//   ID_RegWrite .. ID_ALUOp    decoded control
//   ID_Data1 .. ID_PC4         operands, immediate and PC+4
//   ID_EX_*                    registered copies of the fields above
//   ID_EX_Valid                1 = real instruction, 0 = bubble
//   Load_Use_Stall             to PC / IF_ID: hold fetch and decode this cycle
//   Stall_Count                saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               Hold,
    input  logic               Flush,

    input  logic [4:0]         IF_ID_Rs,
    input  logic [4:0]         IF_ID_Rt,
    input  logic               IF_ID_UsesRt,
    input  logic [4:0]         ID_WriteReg,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemtoReg,
    input  logic               ID_ALUSrc,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [DATA_W-1:0]  ID_Data1,
    input  logic [DATA_W-1:0]  ID_Data2,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic [DATA_W-1:0]  ID_PC4,

    output logic [4:0]         ID_EX_Rs,
    output logic [4:0]         ID_EX_Rt,
    output logic [4:0]         ID_EX_WriteReg,
    output logic               ID_EX_RegWrite,
    output logic               ID_EX_MemRead,
    output logic               ID_EX_MemWrite,
    output logic               ID_EX_MemtoReg,
    output logic               ID_EX_ALUSrc,
    output logic [ALUOP_W-1:0] ID_EX_ALUOp,
    output logic [DATA_W-1:0]  ID_EX_Data1,
    output logic [DATA_W-1:0]  ID_EX_Data2,
    output logic [DATA_W-1:0]  ID_EX_Imm,
    output logic [DATA_W-1:0]  ID_EX_PC4,
    output logic               ID_EX_Valid,

    output logic               Load_Use_Stall,
    output logic [CNT_W-1:0]   Stall_Count
);

    logic rs_hit;
    logic rt_hit;
    logic insert_bubble;
    logic count_stall;

    // A load in EX whose destination is read by the instruction in ID cannot be
    // forwarded in time. $zero is never a real dependency, and rt only matters
    // when the ID instruction actually reads it.
    assign rs_hit = (ID_EX_WriteReg == IF_ID_Rs);
    assign rt_hit = IF_ID_UsesRt & (ID_EX_WriteReg == IF_ID_Rt);

    assign Load_Use_Stall = ID_EX_Valid & ID_EX_MemRead &
                            (ID_EX_WriteReg != 5'd0) & (rs_hit | rt_hit);

    assign insert_bubble = Flush | Load_Use_Stall;

    // A flush already kills the dependent instruction, so a coincident
    // load-use is not a stall of its own and must not be counted.
    assign count_stall = Load_Use_Stall & ~Flush;

    // NOTE: non-blocking assignments here so every field is updated from the
    // values present before the edge; Load_Use_Stall reads these registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ID_EX_Rs       <= '0;
            ID_EX_Rt       <= '0;
            ID_EX_WriteReg <= '0;
            ID_EX_RegWrite <= 1'b0;
            ID_EX_MemRead  <= 1'b0;
            ID_EX_MemWrite <= 1'b0;
            ID_EX_MemtoReg <= 1'b0;
            ID_EX_ALUSrc   <= 1'b0;
            ID_EX_ALUOp    <= '0;
            ID_EX_Data1    <= '0;
            ID_EX_Data2    <= '0;
            ID_EX_Imm      <= '0;
            ID_EX_PC4      <= '0;
            ID_EX_Valid    <= 1'b0;
        end else if (!Hold) begin
            if (insert_bubble) begin
                // Zeroed indices keep the forwarding unit quiet and
                // RegWrite = 0 keeps the later stages from committing.
                ID_EX_Rs       <= '0;
                ID_EX_Rt       <= '0;
                ID_EX_WriteReg <= '0;
                ID_EX_RegWrite <= 1'b0;
                ID_EX_MemRead  <= 1'b0;
                ID_EX_MemWrite <= 1'b0;
                ID_EX_MemtoReg <= 1'b0;
                ID_EX_ALUSrc   <= 1'b0;
                ID_EX_ALUOp    <= '0;
                ID_EX_Data1    <= '0;
                ID_EX_Data2    <= '0;
                ID_EX_Imm      <= '0;
                ID_EX_PC4      <= '0;
                ID_EX_Valid    <= 1'b0;
            end else begin
                ID_EX_Rs       <= IF_ID_Rs;
                ID_EX_Rt       <= IF_ID_Rt;
                ID_EX_WriteReg <= ID_WriteReg;
                ID_EX_RegWrite <= ID_RegWrite;
                ID_EX_MemRead  <= ID_MemRead;
                ID_EX_MemWrite <= ID_MemWrite;
                ID_EX_MemtoReg <= ID_MemtoReg;
                ID_EX_ALUSrc   <= ID_ALUSrc;
                ID_EX_ALUOp    <= ID_ALUOp;
                ID_EX_Data1    <= ID_Data1;
                ID_EX_Data2    <= ID_Data2;
                ID_EX_Imm      <= ID_Imm;
                ID_EX_PC4      <= ID_PC4;
                ID_EX_Valid    <= 1'b1;
            end
        end
    end

    // Saturating perf counter: sticks at all-ones rather than wrapping so a
    // long run never reports a misleadingly small number.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Stall_Count <= '0;
        end else if (!Hold && count_stall && (Stall_Count != {CNT_W{1'b1}})) begin
            Stall_Count <= Stall_Count + CNT_W'(1);
        end
    end

endmodule
